i2c_target_regs: RTL and testbench

//  I2C target (responder) for the far side of the I2C bridge's slave bus: answers one 7-bit address.

---
 rtl/i2c_defs.sv | 30 +++
 rtl/i2c_line_sync.sv | 45 ++++
 rtl/i2c_target_regs.sv | 175 +++++++++++++++++
 tb/tb_i2c_target_regs.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_defs.sv
// Shared definitions for the I2C register target.
// FSM encodings, bit-counter milestones and idle line level.
package i2c_defs;

  localparam int BYTE_W = 8;

  localparam logic [3:0] CNT_LAST    = 4'd7;
  localparam logic [3:0] CNT_ACK_DRV = 4'd8;
  localparam logic [3:0] CNT_ACK_END = 4'd9;

  localparam logic LINE_IDLE = 1'b1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_INDEX,
    S_INDEX_ACK,
    S_WDATA,
    S_WDATA_ACK,
    S_RDATA,
    S_RDATA_ACK,
    S_IGNORE
  } state_t;

  function automatic logic is_active(state_t s);
    return (s != S_IDLE) && (s != S_IGNORE);
  endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// SCL/SDA synchronisers with edge and START/STOP detection.
// Events are decoded from the synchronised samples only.
module i2c_line_sync
  import i2c_defs::*;
(
  input  logic clk,
  input  logic reset,
  input  logic scl,
  input  logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic [1:0] scl_q;
  logic [1:0] sda_q;
  logic       scl_d;
  logic       sda_d;
  logic       scl_s;

  // Two-flop synchronisers plus one delayed copy for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_q <= {2{LINE_IDLE}};
      sda_q <= {2{LINE_IDLE}};
      scl_d <= LINE_IDLE;
      sda_d <= LINE_IDLE;
    end else begin
      scl_q <= {scl_q[0], scl};
      sda_q <= {sda_q[0], sda};
      scl_d <= scl_q[1];
      sda_d <= sda_q[1];
    end
  end

  assign scl_s     = scl_q[1];
  assign sda_s     = sda_q[1];
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target answering one 7-bit address with a byte register file.
// SDA is open-drain; SCL is never driven.
module i2c_target_regs
  import i2c_defs::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h42,
  parameter int         NUM_REGS = 4,
  parameter int         IDX_W    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  SCL,
  inout  wire                   SDA,
  output logic [8*NUM_REGS-1:0] regs_out,
  output logic                  wr_strobe,
  output logic [IDX_W-1:0]      wr_index,
  output logic                  busy
);

  logic scl_rise;
  logic scl_fall;
  logic start_det;
  logic stop_det;
  logic sda_s;

  state_t state;
  state_t state_n;

  logic [3:0]                          cnt;
  logic [BYTE_W-1:0]                   shreg;
  logic [IDX_W-1:0]                    ptr;
  logic                                sda_low;
  logic [NUM_REGS-1:0][BYTE_W-1:0]     regs;

  logic [BYTE_W-1:0] byte_in;
  logic [BYTE_W-1:0] rd_byte;
  logic              last_bit;
  logic              ack_drv;
  logic              ack_end;
  logic              addr_hit;

  i2c_line_sync u_sync (
    .clk       (clk),
    .reset     (reset),
    .scl       (SCL),
    .sda       (SDA),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_s     (sda_s)
  );

  assign SDA      = sda_low ? 1'b0 : 1'bz;
  assign regs_out = regs;

  assign byte_in  = {shreg[BYTE_W-2:0], sda_s};
  assign rd_byte  = regs[ptr];
  assign last_bit = scl_rise && (cnt == CNT_LAST);
  assign ack_drv  = scl_fall && (cnt == CNT_ACK_DRV);
  assign ack_end  = scl_fall && (cnt == CNT_ACK_END);
  assign addr_hit = (byte_in[7:1] == DEV_ADDR);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  // Next-state: bus conditions override, otherwise advance per byte/ACK.
  always_comb begin
    state_n = state;
    if (stop_det) begin
      state_n = S_IDLE;
    end else if (start_det) begin
      state_n = S_ADDR;
    end else begin
      unique case (state)
        S_ADDR:
          if (last_bit) state_n = addr_hit ? S_ADDR_ACK : S_IGNORE;
        S_ADDR_ACK:
          if (ack_end) state_n = shreg[0] ? S_RDATA : S_INDEX;
        S_INDEX:
          if (last_bit) state_n = S_INDEX_ACK;
        S_INDEX_ACK:
          if (ack_end) state_n = S_WDATA;
        S_WDATA:
          if (last_bit) state_n = S_WDATA_ACK;
        S_WDATA_ACK:
          if (ack_end) state_n = S_WDATA;
        S_RDATA:
          if (last_bit) state_n = S_RDATA_ACK;
        S_RDATA_ACK:
          if (ack_end) state_n = shreg[0] ? S_IGNORE : S_RDATA;
        default: ;
      endcase
    end
  end

  // Datapath: shifter, bit counter, pointer, register file and SDA drive.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      shreg     <= '0;
      ptr       <= '0;
      sda_low   <= 1'b0;
      regs      <= '0;
      wr_strobe <= 1'b0;
      wr_index  <= '0;
      busy      <= 1'b0;
    end else begin
      wr_strobe <= 1'b0;
      if (stop_det || start_det) begin
        sda_low <= 1'b0;
        busy    <= 1'b0;
        cnt     <= '0;
      end else begin
        if (scl_rise && is_active(state)) cnt <= cnt + 4'd1;
        case (state)
          S_ADDR: begin
            if (scl_rise) shreg <= byte_in;
            if (last_bit && addr_hit) busy <= 1'b1;
          end
          S_INDEX: begin
            if (scl_rise) shreg <= byte_in;
            if (last_bit) ptr <= byte_in[IDX_W-1:0];
          end
          S_WDATA: begin
            if (scl_rise) shreg <= byte_in;
            if (last_bit) begin
              regs[ptr] <= byte_in;
              wr_strobe <= 1'b1;
              wr_index  <= ptr;
              ptr       <= ptr + IDX_W'(1);
            end
          end
          S_ADDR_ACK, S_INDEX_ACK, S_WDATA_ACK: begin
            if (ack_drv) sda_low <= 1'b1;
            if (ack_end) begin
              cnt <= '0;
              if (state == S_ADDR_ACK && shreg[0]) begin
                sda_low <= ~rd_byte[7];
                shreg   <= {rd_byte[6:0], 1'b0};
              end else begin
                sda_low <= 1'b0;
              end
            end
          end
          S_RDATA: begin
            if (last_bit) ptr <= ptr + IDX_W'(1);
            if (scl_fall) begin
              sda_low <= ~shreg[7];
              shreg   <= {shreg[6:0], 1'b0};
            end
          end
          S_RDATA_ACK: begin
            if (scl_rise) shreg <= byte_in;
            if (ack_drv) sda_low <= 1'b0;
            if (ack_end) begin
              cnt <= '0;
              if (!shreg[0]) begin
                sda_low <= ~rd_byte[7];
                shreg   <= {rd_byte[6:0], 1'b0};
              end else begin
                sda_low <= 1'b0;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_regs.sv
// Directed bench for i2c_target_regs; the bench is the I2C initiator.
// Open-drain lines are tri1 nets pulled high when nobody drives.
module tb_i2c_target_regs;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic scl_low = 1'b0;
  logic sda_low_m = 1'b0;

  tri1 scl_w;
  tri1 sda_w;

  assign scl_w = scl_low ? 1'b0 : 1'bz;
  assign sda_w = sda_low_m ? 1'b0 : 1'bz;

  logic [31:0] regs_out;
  logic        wr_strobe;
  logic [1:0]  wr_index;
  logic        busy;

  int tests = 0;
  int fails = 0;
  int strobes = 0;
  logic [1:0] strobe_idx [8];

  always #5 clk = ~clk;

  i2c_target_regs dut (
    .clk       (clk),
    .reset     (reset),
    .SCL       (scl_w),
    .SDA       (sda_w),
    .regs_out  (regs_out),
    .wr_strobe (wr_strobe),
    .wr_index  (wr_index),
    .busy      (busy)
  );

  // Record every write strobe and its index.
  always @(negedge clk) begin
    if (wr_strobe) begin
      if (strobes < 8) strobe_idx[strobes] = wr_index;
      strobes++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One SCL clock; entry and exit with SCL just pulled low.
  task automatic clock_bit(input logic b, output logic s);
    #25 sda_low_m = ~b;
    #25 scl_low = 1'b0;
    #25 s = sda_w;
    #25 scl_low = 1'b1;
  endtask

  task automatic i2c_start();
    #40 sda_low_m = 1'b0;
    #10 scl_low = 1'b0;
    #25 sda_low_m = 1'b1;
    #25 scl_low = 1'b1;
  endtask

  task automatic i2c_stop();
    #25 sda_low_m = 1'b1;
    #25 scl_low = 1'b0;
    #25 sda_low_m = 1'b0;
    #25;
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
    clock_bit(1'b1, ack);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, s);
      b[i] = s;
    end
    clock_bit(nack, s);
  endtask

  initial begin
    logic       ack;
    logic       s;
    logic       seen;
    logic [7:0] d;

    #30 reset = 1'b0;
    #20;
    check("rst_regs", regs_out, 32'h0);
    check("rst_strobe", {31'b0, wr_strobe}, 32'h0);
    check("rst_index", {30'b0, wr_index}, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_sda", {31'b0, sda_w}, 32'h1);

    // Preload reg0 so the reset below has something to clear.
    i2c_start();
    write_byte(8'h84, ack);
    write_byte(8'h00, ack);
    write_byte(8'h77, ack);
    i2c_stop();
    #50;
    check("pre_reg0", regs_out, 32'h0000_0077);

    // Reset while the target holds the address ACK.
    i2c_start();
    for (int i = 7; i >= 0; i--) begin
      d = 8'h84;
      clock_bit(d[i], s);
    end
    #25 sda_low_m = 1'b0;
    #15;
    check("ack_held", {31'b0, sda_w}, 32'h0);
    check("ack_busy", {31'b0, busy}, 32'h1);
    reset = 1'b1;
    #1;
    check("mid_rst_sda", {31'b0, sda_w}, 32'h1);
    check("mid_rst_regs", regs_out, 32'h0);
    check("mid_rst_busy", {31'b0, busy}, 32'h0);
    #20 reset = 1'b0;
    #30 scl_low = 1'b0;
    #100;

    // Write idx 1: A5, 3C.
    strobes = 0;
    i2c_start();
    write_byte(8'h84, ack);
    check("w_addr_ack", {31'b0, ack}, 32'h0);
    check("w_busy", {31'b0, busy}, 32'h1);
    write_byte(8'h01, ack);
    check("w_idx_ack", {31'b0, ack}, 32'h0);
    write_byte(8'hA5, ack);
    check("w_d0_ack", {31'b0, ack}, 32'h0);
    write_byte(8'h3C, ack);
    check("w_d1_ack", {31'b0, ack}, 32'h0);
    i2c_stop();
    #50;
    check("w_busy_stop", {31'b0, busy}, 32'h0);
    check("w_reg1", {24'b0, regs_out[15:8]}, 32'hA5);
    check("w_reg2", {24'b0, regs_out[23:16]}, 32'h3C);
    check("w_strobes", strobes, 32'd2);
    check("w_sidx0", {30'b0, strobe_idx[0]}, 32'd1);
    check("w_sidx1", {30'b0, strobe_idx[1]}, 32'd2);

    // Index 7 wraps to 3; second byte wraps to reg0.
    strobes = 0;
    i2c_start();
    write_byte(8'h84, ack);
    write_byte(8'h07, ack);
    check("wrap_idx_ack", {31'b0, ack}, 32'h0);
    write_byte(8'h11, ack);
    write_byte(8'hC3, ack);
    check("wrap_d_ack", {31'b0, ack}, 32'h0);
    i2c_stop();
    #50;
    check("wrap_regs", regs_out, 32'h113C_A5C3);
    check("wrap_strobes", strobes, 32'd2);
    check("wrap_sidx0", {30'b0, strobe_idx[0]}, 32'd3);
    check("wrap_sidx1", {30'b0, strobe_idx[1]}, 32'd0);

    // Repeated-START read from idx 3: reg3 then reg0.
    i2c_start();
    write_byte(8'h84, ack);
    write_byte(8'h03, ack);
    i2c_start();
    write_byte(8'h85, ack);
    check("r_addr_ack", {31'b0, ack}, 32'h0);
    read_byte(1'b0, d);
    check("r_byte0", {24'b0, d}, 32'h11);
    read_byte(1'b1, d);
    check("r_byte1", {24'b0, d}, 32'hC3);
    seen = 1'b1;
    for (int i = 0; i < 3; i++) begin
      clock_bit(1'b1, s);
      seen = seen & s;
    end
    check("r_no_drive", {31'b0, seen}, 32'h1);
    i2c_stop();
    #50;

    // Address 0x90 does not match.
    strobes = 0;
    i2c_start();
    write_byte(8'h90, ack);
    check("miss_ack", {31'b0, ack}, 32'h1);
    check("miss_busy", {31'b0, busy}, 32'h0);
    write_byte(8'h12, ack);
    check("miss_d0", {31'b0, ack}, 32'h1);
    write_byte(8'h34, ack);
    check("miss_d1", {31'b0, ack}, 32'h1);
    i2c_stop();
    #50;
    check("miss_regs", regs_out, 32'h113C_A5C3);
    check("miss_strobes", strobes, 32'd0);

    // START after 4 data bits: no write, pointer kept at 2.
    strobes = 0;
    i2c_start();
    write_byte(8'h84, ack);
    write_byte(8'h02, ack);
    clock_bit(1'b1, s);
    clock_bit(1'b0, s);
    clock_bit(1'b1, s);
    clock_bit(1'b0, s);
    i2c_start();
    write_byte(8'h85, ack);
    check("trunc_ack", {31'b0, ack}, 32'h0);
    read_byte(1'b1, d);
    check("trunc_rd", {24'b0, d}, 32'h3C);
    i2c_stop();
    #50;
    check("trunc_strobes", strobes, 32'd0);
    check("trunc_regs", regs_out, 32'h113C_A5C3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
